// File: rtl/car_parking_mgmt_pkg.sv
// car_parking_mgmt_pkg: gate FSM states and active-low 7-seg glyphs {g,f,e,d,c,b,a}
package car_parking_mgmt_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_PASS, WRONG_PASS, RIGHT_PASS, STOP} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b0000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;
endpackage

// File: rtl/parking_seg_decode.sv
// parking_seg_decode: maps the gate state to its two-letter 7-seg message
module parking_seg_decode
    import car_parking_mgmt_pkg::*;
(
    input  state_t     state,
    output logic [6:0] hex_1,
    output logic [6:0] hex_2
);
    always_comb begin
        hex_1 = (state == WAIT_PASS || state == WRONG_PASS) ? SEG_E :
                state == RIGHT_PASS ? SEG_G :
                state == STOP       ? SEG_S : SEG_BLANK;
        hex_2 = state == WAIT_PASS  ? SEG_N :
                state == WRONG_PASS ? SEG_E :
                state == RIGHT_PASS ? SEG_O :
                state == STOP       ? SEG_P : SEG_BLANK;
    end
endmodule

// File: rtl/car_parking_mgmt.sv
// car_parking_mgmt: password-gated car park entry controller with occupancy tracking
module car_parking_mgmt
    import car_parking_mgmt_pkg::*;
#(
    parameter int         CAPACITY    = 8,
    parameter int         WAIT_CYCLES = 3,
    parameter logic [1:0] PASS_1      = 2'b01,
    parameter logic [1:0] PASS_2      = 2'b01
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_entry,
    input  logic       sense_exit,
    input  logic [1:0] password_1,
    input  logic [1:0] password_2,
    output logic       green_light,
    output logic       red_light,
    output logic [6:0] hex_1,
    output logic [6:0] hex_2,
    output logic [3:0] space_available,
    output logic [3:0] space_utilized,
    output logic [3:0] count_cars
);
    localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [3:0] CAP = 4'(CAPACITY);
    state_t state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [3:0] util_nxt, count_nxt;
    logic pass_ok, full, admit;
    assign pass_ok = password_1 == PASS_1 && password_2 == PASS_2;
    assign full = space_utilized == CAP;
    always_comb begin
        state_nxt = state;
        wait_nxt = wait_cnt;
        admit = 1'b0;
        util_nxt = space_utilized;
        case (state)
            IDLE: begin
                if (sense_exit && space_utilized != 4'd0) util_nxt = space_utilized - 4'd1;
                if (sense_entry && !full) begin
                    state_nxt = WAIT_PASS;
                    wait_nxt = '0;
                end
            end
            WAIT_PASS: begin
                wait_nxt = wait_cnt + WW'(1);
                if (wait_cnt == WW'(WAIT_CYCLES - 1)) begin
                    state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
                    admit = pass_ok;
                end
            end
            WRONG_PASS: begin
                state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
                admit = pass_ok;
            end
            RIGHT_PASS: state_nxt = (sense_entry && sense_exit) ? STOP : sense_exit ? IDLE : RIGHT_PASS;
            STOP: begin
                state_nxt = !pass_ok ? STOP : full ? IDLE : RIGHT_PASS;
                admit = pass_ok && !full;
            end
            default: state_nxt = IDLE;
        endcase
        if (admit && !full) util_nxt = space_utilized + 4'd1;
        count_nxt = (admit && count_cars != 4'hf) ? count_cars + 4'd1 : count_cars;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            wait_cnt <= '0;
            space_utilized <= 4'd0;
            count_cars <= 4'd0;
        end else begin
            state <= state_nxt;
            wait_cnt <= wait_nxt;
            space_utilized <= util_nxt;
            count_cars <= count_nxt;
        end
    end
    // red in IDLE flags a car arriving at a full park
    assign green_light = state == RIGHT_PASS;
    assign red_light = state == IDLE ? (full && sense_entry) : state != RIGHT_PASS;
    assign space_available = CAP - space_utilized;
    parking_seg_decode u_seg (.state(state), .hex_1(hex_1), .hex_2(hex_2));
endmodule

// File: tb/tb_car_parking_mgmt.sv
// tb_car_parking_mgmt: randomized scoreboard bench against a behavioural car-park model
module tb_car_parking_mgmt;
    localparam int CAP = 8;
    localparam int WAITC = 3;
    localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_RIGHT = 3, M_STOP = 4;
    localparam bit [6:0] BL = 7'b1111111, GE = 7'b0000110, GN = 7'b0101011,
                         GG = 7'b0000010, GO = 7'b1000000, GS = 7'b0010010, GP = 7'b0001100;
    typedef struct {
        bit g;
        bit r;
        bit [6:0] h1;
        bit [6:0] h2;
        int av;
        int ut;
        int ct;
    } exp_t;
    logic clk = 0, rst = 0, sense_entry = 0, sense_exit = 0;
    logic [1:0] password_1 = 0, password_2 = 0;
    logic green_light, red_light;
    logic [6:0] hex_1, hex_2;
    logic [3:0] space_available, space_utilized, count_cars;
    int errors = 0, checks = 0;
    int m_mode = M_IDLE, m_util = 0, m_cnt = 0, m_wc = 0;
    exp_t q[$];
    car_parking_mgmt dut (
        .clk(clk), .rst(rst), .sense_entry(sense_entry), .sense_exit(sense_exit),
        .password_1(password_1), .password_2(password_2),
        .green_light(green_light), .red_light(red_light), .hex_1(hex_1), .hex_2(hex_2),
        .space_available(space_available), .space_utilized(space_utilized), .count_cars(count_cars)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("green", int'(green_light), int'(e.g));
            chk("red", int'(red_light), int'(e.r));
            chk("hex_1", int'(hex_1), int'(e.h1));
            chk("hex_2", int'(hex_2), int'(e.h2));
            chk("avail", int'(space_available), e.av);
            chk("util", int'(space_utilized), e.ut);
            chk("count", int'(count_cars), e.ct);
        end
    end
    task automatic admit_car();
        if (m_util < CAP) m_util++;
        if (m_cnt < 15) m_cnt++;
    endtask
    task automatic model_edge(input bit r, input bit e, input bit x, input bit ok);
        bit full;
        full = m_util == CAP;
        if (!r) begin
            m_mode = M_IDLE; m_util = 0; m_cnt = 0; m_wc = 0;
        end else if (m_mode == M_IDLE) begin
            if (x && m_util > 0) m_util--;
            if (e && !full) begin m_mode = M_WAIT; m_wc = 0; end
        end else if (m_mode == M_WAIT) begin
            if (m_wc == WAITC - 1) begin
                m_mode = ok ? M_RIGHT : M_WRONG;
                if (ok) admit_car();
            end else m_wc++;
        end else if (m_mode == M_WRONG) begin
            if (ok) begin m_mode = M_RIGHT; admit_car(); end
        end else if (m_mode == M_RIGHT) begin
            if (e && x) m_mode = M_STOP;
            else if (x) m_mode = M_IDLE;
        end else if (ok) begin
            if (!full) begin m_mode = M_RIGHT; admit_car(); end
            else m_mode = M_IDLE;
        end
    endtask
    task automatic step(input bit r, input bit e, input bit x, input bit [1:0] a, input bit [1:0] b, input bit push);
        exp_t ex;
        rst = r; sense_entry = e; sense_exit = x; password_1 = a; password_2 = b;
        if (push) begin
            ex.g = m_mode == M_RIGHT;
            ex.r = m_mode == M_IDLE ? (m_util == CAP && e) : m_mode != M_RIGHT;
            ex.h1 = m_mode == M_IDLE ? BL : m_mode == M_RIGHT ? GG : m_mode == M_STOP ? GS : GE;
            ex.h2 = m_mode == M_IDLE ? BL : m_mode == M_WAIT ? GN : m_mode == M_WRONG ? GE :
                    m_mode == M_RIGHT ? GO : GP;
            ex.av = CAP - m_util;
            ex.ut = m_util;
            ex.ct = m_cnt;
            q.push_back(ex);
        end
        @(posedge clk);
        model_edge(r, e, x, a == 2'b01 && b == 2'b01);
        #1;
    endtask
    task automatic enter_ok();
        step(1, 1, 0, 2'b01, 2'b01, 1);
        repeat (WAITC) step(1, 0, 0, 2'b01, 2'b01, 1);
    endtask
    initial begin
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        enter_ok();
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 1, 0, 2'b00, 2'b11, 1);
        repeat (WAITC + 1) step(1, 0, 0, 2'b00, 2'b11, 1);
        step(1, 0, 0, 2'b01, 2'b01, 1);
        step(1, 1, 1, 2'b00, 2'b00, 1);
        step(1, 0, 0, 2'b10, 2'b01, 1);
        step(1, 0, 0, 2'b01, 2'b01, 1);
        step(1, 0, 1, 0, 0, 1);
        for (int i = 0; i < CAP; i++) begin
            enter_ok();
            step(1, 0, 1, 0, 0, 1);
        end
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            bit good;
            good = $urandom_range(0, 1) == 1;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                 good ? 2'b01 : 2'($urandom), good ? 2'b01 : 2'($urandom), 1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
